req_latch8: RTL and testbench
=============================

Name: req_latch8

Overview:
- Upstream front end for the 8-bit priority encoder.
- Synchronises eight asynchronous request lines, edge-captures them into a pending register, and presents a stable masked snapshot plus enable to the encoder.
- The consumer acknowledges the code it took from the encoder. That acknowledge clears the corresponding pending bit and releases the snapshot for the next round.

Parameters:
SYNC_STAGES  2  synchroniser flop depth per request line; legal values >= 2
LEVEL_MODE  0  0 = rising-edge capture; 1 = level capture, bit re-set every cycle while the synchronised line is high

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  8  asynchronous request lines, bit 7 highest priority downstream
mask_i  input  8  per-bit enable, 1 = bit may enter snapshot
en_i  input  1  global enable
clr_all_i  input  1  synchronous clear of all pending state
ack_i  input  1  consumer has taken a code this cycle
ack_code_i  input  3  index of bit being acknowledged (encoder output)
ovf_clr_i  input  1  clears overflow_o
pend_o  output  8  registered snapshot, feeds encoder in
pend_en_o  output  1  registered, feeds encoder en
overflow_o  output  8  sticky: new edge arrived while bit already pending
busy_o  output  1  FSM in BUSY

Behaviour:
Reset:
- rst_n low forces, asynchronously: sync chains = 0, edge-history = 0, pend_raw = 0, pend_o = 0, pend_en_o = 0, overflow_o = 0, busy_o = 0, state = IDLE.

Capture path:
- req_i passes through SYNC_STAGES flops to give s. prev holds s delayed by one cycle. rise = s & ~prev.
- LEVEL_MODE=0: set = rise.
- LEVEL_MODE=1: set = s, and overflow_o is held at 0.
- pend_raw[i] next value:
  - 0 if clr_all_i (set is discarded that cycle).
  - Otherwise 1 if set[i].
  - Otherwise 0 if the clear condition holds: ack_i, state BUSY, and ack_code_i==i.
  - Otherwise hold.
- Set wins over ack-clear on the same bit in the same cycle.
- overflow_o[i] sets when set[i], pend_raw[i]==1, and bit i is not being ack-cleared that cycle.
- ovf_clr_i clears overflow_o; a simultaneous set of overflow_o wins. clr_all_i does not clear overflow_o.
- Capture is independent of mask_i and en_i.

FSM (two states):
- IDLE:
  - pend_en_o = 0, pend_o = 0.
  - If en_i, !clr_all_i, and (pend_raw & mask_i) != 0: pend_o <= pend_raw & mask_i, pend_en_o <= 1, go BUSY.
  - ack_i is ignored in IDLE.
- BUSY:
  - pend_o is frozen; mask_i and new captures do not alter it.
  - On ack_i: pend_o <= 0, pend_en_o <= 0, go IDLE. pend_raw is cleared per the rule above, even if bit ack_code_i was already 0 (no-op clear).
  - If en_i==0 or clr_all_i, without ack: same exit to IDLE, and pend_raw is cleared only by clr_all_i.
- Minimum service cycle: BUSY → IDLE → BUSY. There is one IDLE cycle between snapshots, so the next snapshot reflects the post-ack pend_raw.

Latency:
- req_i stable high before clk edge 0 → pend_raw bit set after edge SYNC_STAGES+1 → pend_o/pend_en_o valid after edge SYNC_STAGES+2. That is 4 edges for the default depth, with FSM idle and bit unmasked.

Boundaries:
- All 8 bits pending are serviced one per ack, highest first, because the encoder selects.
- A request pulse shorter than one clk period may be missed; this is by design, and callers stretch the pulse.
- Reset mid-BUSY drops the snapshot and all pending bits.

Test Plan:
- Reset, then pulse req_i=8'h24 (held 3 cycles), mask=FF, en=1 → after 4 edges pend_o=8'h24, pend_en_o=1, busy_o=1. ack_code=5 → next cycle IDLE, pend_raw=8'h04. One cycle later pend_o=8'h04.
- BUSY with pend_o=8'h80; raise req_i[0] and change mask_i to 8'h01 → pend_o stays 8'h80 until ack(7). Next snapshot = 8'h01.
- Bit 3 pending; second rising edge on bit 3 arriving in the same cycle as ack(3) → pend_raw[3] stays 1, overflow_o[3]=0. Same edge without ack → overflow_o=8'h08 (sticky) until ovf_clr_i.
- pend_raw=8'hFF, mask=8'h0F, en_i=0 → pend_en_o stays 0. Set en_i=1 → pend_o=8'h0F. clr_all_i in BUSY → IDLE, pend_raw=0, overflow unchanged.
- LEVEL_MODE=1, req_i[2] held high, ack(2) repeatedly → bit re-pends each round, overflow_o stays 0. Drop rst_n mid-BUSY → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/req_latch8.sv
// Request front end for the 8-bit priority encoder: synchronises async request lines,
// captures them into a pending register and hands out a frozen, masked snapshot per round.
module req_latch8 #(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL_MODE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic [7:0] mask_i,
  input  logic       en_i,
  input  logic       clr_all_i,
  input  logic       ack_i,
  input  logic [2:0] ack_code_i,
  input  logic       ovf_clr_i,
  output logic [7:0] pend_o,
  output logic       pend_en_o,
  output logic [7:0] overflow_o,
  output logic       busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] prev_q;
  logic [7:0] pend_raw_q, pend_raw_d;
  logic [7:0] ovf_q, ovf_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_en_q, pend_en_d;
  logic [0:0] state_q, state_d;

  logic [7:0] s;
  logic [7:0] rise;
  logic [7:0] set_vec;
  logic [7:0] ack_clr;
  logic [7:0] ovf_set;
  logic [7:0] snap;

  // Synchroniser chain plus one-cycle history for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the sync chain is reset too, so no stale metastable-era value can fake an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= s;
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~prev_q;
  assign set_vec = LEVEL_MODE ? s : rise;

  // Ack only clears pending state while a snapshot is outstanding.
  assign ack_clr = (ack_i && (state_q == BUSY)) ? (8'd1 << ack_code_i) : 8'd0;

  // A new event on a bit that is still pending (and not being retired) is an overrun.
  assign ovf_set = LEVEL_MODE ? 8'd0 : (set_vec & pend_raw_q & ~ack_clr);

  always_comb begin
    pend_raw_d = pend_raw_q;
    if (clr_all_i) begin
      pend_raw_d = '0;
    end else begin
      pend_raw_d = set_vec | (pend_raw_q & ~ack_clr);
    end
  end

  // Sticky overflow: clear request loses to a simultaneous new overrun.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = '0;
    end
    ovf_d = ovf_d | ovf_set;
  end

  assign snap = pend_raw_q & mask_i;

  // Snapshot FSM: IDLE loads a masked copy, BUSY holds it until ack, disable or clear-all.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_en_d = pend_en_q;
    case (state_q)
      IDLE: begin
        pend_d    = '0;
        pend_en_d = 1'b0;
        if (en_i && !clr_all_i && (snap != 8'd0)) begin
          pend_d    = snap;
          pend_en_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (ack_i || !en_i || clr_all_i) begin
          pend_d    = '0;
          pend_en_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        pend_d    = '0;
        pend_en_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_raw_q <= '0;
      ovf_q      <= '0;
      pend_q     <= '0;
      pend_en_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      pend_raw_q <= pend_raw_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_en_q  <= pend_en_d;
      state_q    <= state_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_en_o  = pend_en_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q == BUSY);

endmodule

// File: tb/tb_req_latch8.sv
// Directed bench for req_latch8: an edge-mode and a level-mode instance, with scoreboard
// monitors that pop the expected snapshot each time pend_en_o rises.
module tb_req_latch8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask;
  logic       en, clr_all, ack, ovf_clr;
  logic [2:0] code;
  logic [7:0] pend, ovf;
  logic       pend_en, busy;

  logic [7:0] l_req;
  logic       l_ack;
  logic [2:0] l_code;
  logic [7:0] l_pend, l_ovf;
  logic       l_pend_en, l_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_l[$];

  always #5 clk = ~clk;

  req_latch8 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .mask_i(mask), .en_i(en),
    .clr_all_i(clr_all), .ack_i(ack), .ack_code_i(code), .ovf_clr_i(ovf_clr),
    .pend_o(pend), .pend_en_o(pend_en), .overflow_o(ovf), .busy_o(busy)
  );

  req_latch8 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_i(l_req), .mask_i(mask), .en_i(en),
    .clr_all_i(clr_all), .ack_i(l_ack), .ack_code_i(l_code), .ovf_clr_i(ovf_clr),
    .pend_o(l_pend), .pend_en_o(l_pend_en), .overflow_o(l_ovf), .busy_o(l_busy)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitors: one pop per new snapshot presented to the encoder.
  logic prev_en = 1'b0, prev_en_l = 1'b0;
  always @(negedge clk) begin
    if (pend_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL snapshot: got %h with no expected value at %0t", pend, $time);
      end else begin
        check("snapshot", pend, exp_q.pop_front());
      end
    end
    if (l_pend_en && !prev_en_l) begin
      if (exp_l.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL l_snapshot: got %h with no expected value at %0t", l_pend, $time);
      end else begin
        check("l_snapshot", l_pend, exp_l.pop_front());
      end
    end
    prev_en   = pend_en;
    prev_en_l = l_pend_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; mask = 8'hFF; en = 1'b1; clr_all = 1'b0;
    ack = 1'b0; code = '0; ovf_clr = 1'b0;
    l_req = '0; l_ack = 1'b0; l_code = '0;
    #1;
    check("reset_pend", pend, 8'h00);
    check("reset_en_busy_ovf", {6'd0, pend_en, busy}, 8'h00);
    check("reset_ovf", ovf, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Round 1: two-bit request, ack the higher bit, remainder re-snapshots.
    req = 8'h24; exp_q.push_back(8'h24);
    tick(3);
    req = 8'h00;
    check("latency_not_yet", {7'd0, pend_en}, 8'h00);
    tick(1);
    check("t1_pend", pend, 8'h24);
    check("t1_en_busy", {6'd0, pend_en, busy}, 8'h03);
    ack = 1'b1; code = 3'd5; exp_q.push_back(8'h04);
    tick(1);
    ack = 1'b0;
    check("t1_idle_gap", {6'd0, pend_en, busy}, 8'h00);
    tick(1);
    check("t1_second", pend, 8'h04);
    ack = 1'b1; code = 3'd2;
    tick(1);
    ack = 1'b0;
    tick(3);
    check("t1_drained", {7'd0, pend_en}, 8'h00);

    // Round 2: snapshot frozen against new captures and mask changes.
    req = 8'h80; exp_q.push_back(8'h80);
    tick(4);
    check("t2_pend", pend, 8'h80);
    req = 8'h01; mask = 8'h01;
    tick(5);
    check("t2_frozen", pend, 8'h80);
    check("t2_still_busy", {7'd0, busy}, 8'h01);
    ack = 1'b1; code = 3'd7; exp_q.push_back(8'h01);
    tick(1);
    ack = 1'b0;
    tick(1);
    check("t2_next", pend, 8'h01);
    ack = 1'b1; code = 3'd0;
    tick(1);
    ack = 1'b0; mask = 8'hFF; req = 8'h00;
    tick(3);
    check("t2_drained", {7'd0, pend_en}, 8'h00);

    // Round 3: new edge coincident with ack keeps the bit, then a real overrun.
    req = 8'h08; exp_q.push_back(8'h08);
    tick(3);
    req = 8'h00;
    tick(1);
    check("t3_pend", pend, 8'h08);
    tick(2);
    req = 8'h08;
    tick(2);
    ack = 1'b1; code = 3'd3; exp_q.push_back(8'h08);
    tick(1);
    ack = 1'b0;
    check("t3_no_ovf", ovf, 8'h00);
    tick(1);
    check("t3_repend", pend, 8'h08);
    req = 8'h00;
    tick(3);
    req = 8'h08;
    tick(2);
    check("t3_ovf_before", ovf, 8'h00);
    tick(1);
    check("t3_ovf_set", ovf, 8'h08);
    req = 8'h00;
    tick(3);
    check("t3_ovf_sticky", ovf, 8'h08);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t3_ovf_clr", ovf, 8'h00);
    ack = 1'b1; code = 3'd3;
    tick(1);
    ack = 1'b0;
    tick(3);
    check("t3_drained", {7'd0, pend_en}, 8'h00);

    // Round 4: enable gating, masked snapshot, clr_all in BUSY keeps overflow.
    en = 1'b0; mask = 8'h0F;
    req = 8'hFF;
    tick(3);
    req = 8'h00;
    tick(3);
    req = 8'h02;
    tick(3);
    req = 8'h00;
    check("t4_en_gated", {7'd0, pend_en}, 8'h00);
    check("t4_ovf", ovf, 8'h02);
    en = 1'b1; exp_q.push_back(8'h0F);
    tick(1);
    check("t4_masked", pend, 8'h0F);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    check("t4_clr_exit", {6'd0, pend_en, busy}, 8'h00);
    check("t4_ovf_kept", ovf, 8'h02);
    mask = 8'hFF;
    tick(4);
    check("t4_raw_cleared", {7'd0, pend_en}, 8'h00);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;

    // Round 5: level mode re-pends a held line every round without overflow.
    l_req = 8'h04; exp_l.push_back(8'h04);
    tick(4);
    check("t5_pend", l_pend, 8'h04);
    for (int r = 0; r < 3; r++) begin
      l_ack = 1'b1; l_code = 3'd2; exp_l.push_back(8'h04);
      tick(1);
      l_ack = 1'b0;
      check("t5_gap", {7'd0, l_pend_en}, 8'h00);
      tick(1);
      check("t5_repend", l_pend, 8'h04);
      check("t5_no_ovf", l_ovf, 8'h00);
    end
    check("t5_busy", {7'd0, l_busy}, 8'h01);

    // Asynchronous reset mid-BUSY, observed before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pend", l_pend, 8'h00);
    check("rst_async_flags", {6'd0, l_pend_en, l_busy}, 8'h00);
    check("rst_async_ovf", l_ovf | ovf | pend, 8'h00);

    check("queue_empty", 8'(exp_q.size() + exp_l.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
